dp_block_ram_fwd: RTL and testbench
===================================

DP_BLOCK_RAM_FWD -- requirements
Module: dp_block_ram_fwd

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bits per word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address bits; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter RD_LATENCY, default 3, read edges from sampled request to output; legal range 2..6.
REQ-004 SHALL have parameter WRITE_FIRST, default 1:
- 1 = same-edge write is visible to the read.
- 0 = read returns the old data.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port sync_reset  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port wea  input  1  write strobe, port A.
REQ-008 SHALL have port addra  input  ADDR_WIDTH  write address.
REQ-009 SHALL have port dia  input  DATA_WIDTH  write data.
REQ-010 SHALL have port reb  input  1  read request, port B.
REQ-011 SHALL have port addrb  input  ADDR_WIDTH  read address.
REQ-012 SHALL have port dob  output  DATA_WIDTH  read data, registered.
REQ-013 SHALL have port dob_valid  output  1  high for exactly one cycle per accepted read.
REQ-014 SHALL have port dob_coll  output  1  qualifies dob_valid: the read address equalled addra of a write sampled on the same edge.

Function
REQ-015 SHALL infer the storage array as block RAM, initialised to all zeros at configuration.
REQ-016 SHALL sample a write when wea=1 and sync_reset=0 at edge N, and commit it to the array at edge N+1.
REQ-017 SHALL sample a read when reb=1 and sync_reset=0 at edge M, and present dob with dob_valid=1 after edge M+RD_LATENCY.
REQ-018 SHALL accept one read and one write per edge, back-to-back, with no stall, for any address mix.
REQ-019 WRITE_FIRST=1: a read sampled at edge M SHALL return the data of the latest write to that address sampled at or before edge M.
REQ-020 WRITE_FIRST=0: a read sampled at edge M SHALL return the data of the latest write to that address sampled strictly before edge M.
REQ-021 Writes sampled before M but not yet committed, or committed during the read pipeline, SHALL be forwarded so that REQ-019/REQ-020 hold exactly.
REQ-022 Forwarding SHALL select the youngest qualifying write when several in-flight writes match the address.
REQ-023 dob SHALL hold its last value when dob_valid=0.
REQ-024 dob_coll SHALL be 1 only in the dob_valid cycle of a read whose addrb equalled addra of a write sampled on the same edge, and 0 otherwise.
REQ-025 Address wrap-around SHALL be natural modulo 2**ADDR_WIDTH; no out-of-range handling.

Reset
REQ-026 While sync_reset=1, dob SHALL be 0, and dob_valid and dob_coll SHALL be 0 from the following edge.
REQ-027 sync_reset SHALL discard all in-flight reads; their dob_valid pulses SHALL never appear.
REQ-028 A write sampled at the edge before reset asserts SHALL still commit; array contents SHALL NOT be cleared by reset.
REQ-029 wea and reb SHALL be ignored on edges where sync_reset=1; the first request SHALL be accepted on the first edge with sync_reset=0.

Verification
REQ-030 Basic read: write 0xDEADBEEF to addr 0x10, idle 5 cycles, then read 0x10 -> dob=0xDEADBEEF with dob_valid exactly 3 cycles after the read, dob_coll=0.
REQ-031 Same-edge collision: memory[0x20]=0x1; on one edge write 0x2 to 0x20 and read 0x20:
- WRITE_FIRST=1 -> dob=0x2, dob_coll=1.
- WRITE_FIRST=0 -> dob=0x1, dob_coll=1.
REQ-032 Pipeline forwarding: write 0xA to addr 5 at edge N, read addr 5 at edge N+1 -> dob=0xA (both modes).
REQ-033 Youngest-write select: writes 0x1, 0x2, 0x3 to addr 7 on consecutive edges, then read addr 7 on the next edge -> dob=0x3.
REQ-034 Reset mid-operation: reads issued on 3 consecutive edges, then sync_reset pulsed for 1 cycle -> no dob_valid pulses and dob=0; a write sampled before the reset edge reads back afterwards.
REQ-035 Streaming and latency: random back-to-back reads and writes compared against a reference model, repeated for RD_LATENCY=2 and RD_LATENCY=6 -> zero mismatches, and dob_valid count equals the accepted read count.

Source files
------------

// File: rtl/dp_block_ram_fwd.sv
// Simple dual-port block RAM: port A writes, port B reads with a fixed read
// latency. In-flight writes are forwarded so every read sees the latest sampled write.
module dp_block_ram_fwd #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int RD_LATENCY  = 3,
  parameter bit WRITE_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dia,
  input  logic                  reb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] dob,
  output logic                  dob_valid,
  output logic                  dob_coll
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  // Registers between the RAM output register and dob.
  localparam int NPIPE = RD_LATENCY - 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  wr_vld_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic                  coll_d;
  logic                  fwd_hit_d;
  logic [DATA_WIDTH-1:0] fwd_data_d;

  logic                  vld_p0_q;
  logic                  coll_p0_q;
  logic                  fwd_hit_p0_q;
  logic [DATA_WIDTH-1:0] fwd_data_p0_q;
  logic [DATA_WIDTH-1:0] ram_p0_q;

  logic [NPIPE:1]        vld_pn_q;
  logic [NPIPE:1]        coll_pn_q;
  logic [DATA_WIDTH-1:0] data_pn_q [1:NPIPE];

  logic [DATA_WIDTH-1:0] dob_q;
  logic                  dob_valid_q;
  logic                  dob_coll_q;

  function automatic logic [DATA_WIDTH-1:0] fwd_sel(
    input logic                  hit,
    input logic [DATA_WIDTH-1:0] fwd,
    input logic [DATA_WIDTH-1:0] ram
  );
    return hit ? fwd : ram;
  endfunction

  assign wr_acc = wea & ~sync_reset;
  assign rd_acc = reb & ~sync_reset;

  // Write capture: a sampled write waits one edge in these registers before commit.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_vld_q <= 1'b0;
    end else begin
      wr_vld_q <= wea;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      wr_addr_q <= addra;
      wr_data_q <= dia;
    end
  end

  // Commit is deliberately not gated by reset so a pre-reset write still lands.
  always_ff @(posedge clk) begin
    if (wr_vld_q) begin
      mem[wr_addr_q] <= wr_data_q;
    end
  end

  // The array read misses the write committing on this edge and the write
  // sampled on this edge; both are resolved here, youngest first.
  always_comb begin
    coll_d     = wr_acc && (addra == addrb);
    fwd_hit_d  = 1'b0;
    fwd_data_d = wr_data_q;
    if (WRITE_FIRST && coll_d) begin
      fwd_hit_d  = 1'b1;
      fwd_data_d = dia;
    end else if (wr_vld_q && (wr_addr_q == addrb)) begin
      fwd_hit_d  = 1'b1;
      fwd_data_d = wr_data_q;
    end
  end

  // Stage p0: RAM read register and forwarding decision
  always_ff @(posedge clk) begin
    if (rd_acc) begin
      ram_p0_q <= mem[addrb];
    end
  end

  always_ff @(posedge clk) begin
    fwd_hit_p0_q  <= fwd_hit_d;
    fwd_data_p0_q <= fwd_data_d;
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      vld_p0_q  <= 1'b0;
      coll_p0_q <= 1'b0;
    end else begin
      vld_p0_q  <= reb;
      coll_p0_q <= reb & coll_d;
    end
  end

  // Stages p1..pN: delay line padding the read out to RD_LATENCY
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      vld_pn_q  <= '0;
      coll_pn_q <= '0;
    end else begin
      vld_pn_q[1]  <= vld_p0_q;
      coll_pn_q[1] <= coll_p0_q;
      for (int k = 2; k <= NPIPE; k++) begin
        vld_pn_q[k]  <= vld_pn_q[k-1];
        coll_pn_q[k] <= coll_pn_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    data_pn_q[1] <= fwd_sel(fwd_hit_p0_q, fwd_data_p0_q, ram_p0_q);
    for (int k = 2; k <= NPIPE; k++) begin
      data_pn_q[k] <= data_pn_q[k-1];
    end
  end

  // Output stage: dob holds between valid pulses
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      dob_q       <= '0;
      dob_valid_q <= 1'b0;
      dob_coll_q  <= 1'b0;
    end else begin
      dob_valid_q <= vld_pn_q[NPIPE];
      dob_coll_q  <= vld_pn_q[NPIPE] & coll_pn_q[NPIPE];
      if (vld_pn_q[NPIPE]) begin
        dob_q <= data_pn_q[NPIPE];
      end
    end
  end

  assign dob       = dob_q;
  assign dob_valid = dob_valid_q;
  assign dob_coll  = dob_coll_q;

endmodule

// File: tb/tb_dp_block_ram_fwd.sv
// Directed bench for dp_block_ram_fwd: four instances (latency/mode variants)
// share one stimulus and are checked each cycle against a reference memory model.
module tb_dp_block_ram_fwd;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic        wea;
  logic [7:0]  addra;
  logic [31:0] dia;
  logic        reb;
  logic [7:0]  addrb;

  logic [31:0] dob0, dob1, dob2, dob3;
  logic        vld0, vld1, vld2, vld3;
  logic        col0, col1, col2, col3;

  logic [31:0] dob_s [4];
  logic        vld_s [4];
  logic        col_s [4];

  assign dob_s[0] = dob0; assign dob_s[1] = dob1; assign dob_s[2] = dob2; assign dob_s[3] = dob3;
  assign vld_s[0] = vld0; assign vld_s[1] = vld1; assign vld_s[2] = vld2; assign vld_s[3] = vld3;
  assign col_s[0] = col0; assign col_s[1] = col1; assign col_s[2] = col2; assign col_s[3] = col3;

  // Instance i: latency LAT[i], write-first WFA[i]
  localparam int LAT [4] = '{3, 3, 2, 6};
  localparam bit WFA [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  dp_block_ram_fwd #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RD_LATENCY(3), .WRITE_FIRST(1'b1)) u_wf1 (
    .clk(clk), .sync_reset(sync_reset), .wea(wea), .addra(addra), .dia(dia),
    .reb(reb), .addrb(addrb), .dob(dob0), .dob_valid(vld0), .dob_coll(col0));
  dp_block_ram_fwd #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RD_LATENCY(3), .WRITE_FIRST(1'b0)) u_wf0 (
    .clk(clk), .sync_reset(sync_reset), .wea(wea), .addra(addra), .dia(dia),
    .reb(reb), .addrb(addrb), .dob(dob1), .dob_valid(vld1), .dob_coll(col1));
  dp_block_ram_fwd #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RD_LATENCY(2), .WRITE_FIRST(1'b1)) u_l2 (
    .clk(clk), .sync_reset(sync_reset), .wea(wea), .addra(addra), .dia(dia),
    .reb(reb), .addrb(addrb), .dob(dob2), .dob_valid(vld2), .dob_coll(col2));
  dp_block_ram_fwd #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RD_LATENCY(6), .WRITE_FIRST(1'b0)) u_l6 (
    .clk(clk), .sync_reset(sync_reset), .wea(wea), .addra(addra), .dia(dia),
    .reb(reb), .addrb(addrb), .dob(dob3), .dob_valid(vld3), .dob_coll(col3));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem_m [256];
  logic        ln_v [4][7];
  logic [31:0] ln_d [4][7];
  logic        ln_c [4][7];
  logic [31:0] exp_dob [4];
  int          pulses [4];
  int          rd_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge: update the reference model from the sampled inputs, then check all instances.
  task automatic step();
    logic        rst_s, mv, mc;
    logic [31:0] d0, d1;
    @(posedge clk);
    rst_s = sync_reset;
    mv = 1'b0; mc = 1'b0; d0 = '0; d1 = '0;
    if (!rst_s) begin
      mv = reb;
      mc = reb && wea && (addra == addrb);
      d0 = mem_m[addrb];
      d1 = (wea && (addra == addrb)) ? dia : d0;
      if (wea) mem_m[addra] = dia;
    end
    for (int i = 0; i < 4; i++) begin
      for (int k = 6; k > 0; k--) begin
        ln_v[i][k] = ln_v[i][k-1];
        ln_d[i][k] = ln_d[i][k-1];
        ln_c[i][k] = ln_c[i][k-1];
      end
      ln_v[i][0] = mv;
      ln_d[i][0] = WFA[i] ? d1 : d0;
      ln_c[i][0] = mc;
      if (rst_s) begin
        for (int k = 0; k < 7; k++) ln_v[i][k] = 1'b0;
        exp_dob[i] = '0;
      end else if (ln_v[i][LAT[i]]) begin
        exp_dob[i] = ln_d[i][LAT[i]];
      end
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("i%0d_valid", i), {31'b0, vld_s[i]}, {31'b0, ln_v[i][LAT[i]]});
      chk($sformatf("i%0d_dob", i), dob_s[i], exp_dob[i]);
      chk($sformatf("i%0d_coll", i), {31'b0, col_s[i]},
          {31'b0, ln_v[i][LAT[i]] & ln_c[i][LAT[i]]});
      if (vld_s[i] === 1'b1) pulses[i]++;
    end
  endtask

  task automatic drive(input logic w, input logic [7:0] wa, input logic [31:0] wd,
                       input logic r, input logic [7:0] ra);
    wea = w; addra = wa; dia = wd; reb = r; addrb = ra;
    step();
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
  endtask

  initial begin
    sync_reset = 1'b1;
    wea = 1'b0; addra = '0; dia = '0; reb = 1'b0; addrb = '0;
    rd_cnt = 0;
    for (int a = 0; a < 256; a++) mem_m[a] = '0;
    for (int i = 0; i < 4; i++) begin
      exp_dob[i] = '0;
      pulses[i]  = 0;
      for (int k = 0; k < 7; k++) begin
        ln_v[i][k] = 1'b0; ln_d[i][k] = '0; ln_c[i][k] = 1'b0;
      end
    end

    repeat (3) step();
    chk("rst_dob", dob_s[0], 32'h0);
    chk("rst_valid", {31'b0, vld_s[0]}, 32'h0);

    // Bring the array to a known all-zero state.
    sync_reset = 1'b0;
    for (int a = 0; a < 256; a++) drive(1'b1, 8'(a), 32'h0, 1'b0, 8'h00);

    // Basic read, exactly three edges of latency
    drive(1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 8'h00);
    repeat (5) idle();
    drive(1'b0, 8'h00, 32'h0, 1'b1, 8'h10);
    idle(); idle();
    chk("basic_early", {31'b0, vld_s[0]}, 32'h0);
    idle();
    chk("basic_valid", {31'b0, vld_s[0]}, 32'h1);
    chk("basic_dob", dob_s[0], 32'hDEADBEEF);
    chk("basic_coll", {31'b0, col_s[0]}, 32'h0);

    // Same-edge collision
    drive(1'b1, 8'h20, 32'h1, 1'b0, 8'h00);
    idle();
    drive(1'b1, 8'h20, 32'h2, 1'b1, 8'h20);
    repeat (3) idle();
    chk("coll_wf1_dob", dob_s[0], 32'h2);
    chk("coll_wf1_coll", {31'b0, col_s[0]}, 32'h1);
    chk("coll_wf0_dob", dob_s[1], 32'h1);
    chk("coll_wf0_coll", {31'b0, col_s[1]}, 32'h1);

    // Read one edge after the write
    drive(1'b1, 8'h05, 32'hA, 1'b0, 8'h00);
    drive(1'b0, 8'h00, 32'h0, 1'b1, 8'h05);
    repeat (3) idle();
    chk("fwd_wf1_dob", dob_s[0], 32'hA);
    chk("fwd_wf0_dob", dob_s[1], 32'hA);
    chk("fwd_wf1_coll", {31'b0, col_s[0]}, 32'h0);

    // Youngest of several in-flight writes
    drive(1'b1, 8'h07, 32'h1, 1'b0, 8'h00);
    drive(1'b1, 8'h07, 32'h2, 1'b0, 8'h00);
    drive(1'b1, 8'h07, 32'h3, 1'b0, 8'h00);
    drive(1'b0, 8'h00, 32'h0, 1'b1, 8'h07);
    repeat (3) idle();
    chk("young_wf1_dob", dob_s[0], 32'h3);
    chk("young_wf0_dob", dob_s[1], 32'h3);
    drive(1'b1, 8'h07, 32'h4, 1'b1, 8'h07);
    repeat (3) idle();
    chk("young_same_wf1", dob_s[0], 32'h4);
    chk("young_same_wf0", dob_s[1], 32'h3);

    // Reset mid-operation, requests during reset must be ignored
    drive(1'b0, 8'h00, 32'h0, 1'b1, 8'h10);
    drive(1'b0, 8'h00, 32'h0, 1'b1, 8'h20);
    drive(1'b1, 8'h09, 32'h55, 1'b1, 8'h05);
    sync_reset = 1'b1;
    drive(1'b1, 8'h09, 32'h99, 1'b1, 8'h09);
    sync_reset = 1'b0;
    chk("rst_mid_dob", dob_s[0], 32'h0);
    chk("rst_mid_dob_l2", dob_s[2], 32'h0);
    chk("rst_mid_valid_l6", {31'b0, vld_s[3]}, 32'h0);
    for (int c = 0; c < 7; c++) begin
      idle();
      chk("rst_drop_wf1", {31'b0, vld_s[0]}, 32'h0);
      chk("rst_drop_l6", {31'b0, vld_s[3]}, 32'h0);
    end
    drive(1'b0, 8'h00, 32'h0, 1'b1, 8'h09);
    repeat (3) idle();
    chk("rst_keep_wf1", dob_s[0], 32'h55);
    chk("rst_keep_wf0", dob_s[1], 32'h55);
    repeat (4) idle();

    // Random back-to-back traffic on a narrow address window
    for (int i = 0; i < 4; i++) pulses[i] = 0;
    rd_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      logic w, r;
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (r) rd_cnt++;
      drive(w, 8'($urandom_range(0, 15)), $urandom, r, 8'($urandom_range(0, 15)));
    end
    repeat (8) idle();
    for (int i = 0; i < 4; i++) chk($sformatf("i%0d_pulse_count", i), 32'(pulses[i]), 32'(rd_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
